led_strip_animator: RTL and testbench
=====================================

Name: led_strip_animator

Overview:
- Parametrised successor to the fixed 6-LED shifter FSM. It drives a WS2812-style single-wire LED strip directly and generates the bit timing internally, so it needs no external per-bit driver.
- It holds a frame buffer of NUM_LEDS words and streams the buffer once per frame. Between frames it inserts a low latch/gap period, then rotates the buffer forward or backward, or holds it, according to the selected mode.
- It sits between the pattern source (MCU/SPI register block) and the strip data pin.

Parameters:
- NUM_LEDS, 6, number of LEDs (words) in the strip.
- BPL, 24, bits per LED word (GRB).
- T0H_CYC, 19, high cycles for a '0' bit.
- T1H_CYC, 38, high cycles for a '1' bit.
- TBIT_CYC, 60, total cycles per bit. Constraint: T0H_CYC < T1H_CYC < TBIT_CYC.
- FRAME_GAP_CYC, 720000, low cycles after the last bit of a frame. Constraint: must be at least the strip latch time (≥ 2400 at 48 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run frames while high.
- mode  in  2  00 static, 01 rotate forward, 10 rotate reverse, 11 blank.
- load_req  in  1  one-cycle pulse; capture frame_data.
- frame_data  in  NUM_LEDS*BPL  new pattern. LED0 is the top word [NUM_LEDS*BPL-1 -: BPL].
- dout  out  1  registered strip data line.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse on the last gap cycle.
- frame_count  out  16  number of completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset values: dout=0, busy=0, frame_done=0, frame_count=0, buffer=0, pending=0, state=IDLE. Reset mid-frame forces dout=0 on the next edge and discards the frame.

States:
- IDLE
  - load_req writes frame_data directly into the buffer.
  - enable=1 -> LOAD.
- LOAD (1 cycle)
  - If pending is set, copy the pending data into the buffer first; pending is cleared.
  - Copy the buffer into the transmit shift register.
  - Set bit_ctr=0, cyc_ctr=0; go to SEND.
  - The first dout high appears on the cycle after LOAD.
- SEND
  - Each bit lasts exactly TBIT_CYC cycles.
  - dout=1 for cycles 0..TxH_CYC-1 of the bit, where TxH_CYC is T1H_CYC if the bit is 1 and T0H_CYC if 0; dout=0 for the rest of the bit.
  - Bit order: MSB of the whole shift register first (LED0 MSB first, then LED1, ...). The register shifts left one position per bit.
  - In mode 11 every bit is transmitted as '0'; the buffer is untouched.
  - After bit NUM_LEDS*BPL-1 completes -> GAP.
- GAP
  - dout=0 for FRAME_GAP_CYC cycles.
  - On the last cycle: frame_done=1, frame_count+1, and the buffer is updated.
  - Buffer update rule: if pending is set, no update here (pending is applied at the next LOAD, unrotated). Otherwise:
    - mode 01: buf <= {buf[W-BPL-1:0], buf[W-1 -: BPL]}.
    - mode 10: buf <= {buf[BPL-1:0], buf[W-1:BPL]}.
    - mode 00 / 11: hold.
  - Next state: LOAD if enable=1, else IDLE.

Rules:
- load_req while busy sets pending and captures frame_data into a pending register (last request wins). The frame in progress is unaffected.
- enable deasserted mid-frame: the current frame, including its gap, completes, then the block goes to IDLE.
- mode is sampled only at the GAP end cycle for rotation, and per bit for blanking. A change mid-frame takes effect from the next bit for blanking.
- Frame length in cycles = 1 (LOAD) + NUM_LEDS*BPL*TBIT_CYC + FRAME_GAP_CYC.
- Counter widths use $clog2 of their terminal values. No combinational path from inputs to dout.

Test Plan (params NUM_LEDS=3, BPL=8, T0H_CYC=2, T1H_CYC=4, TBIT_CYC=6, FRAME_GAP_CYC=20):
1. load_req with {A5,00,FF}, mode=00, enable=1 -> first-byte high widths 4,2,4,2,2,4,2,4 on a 6-cycle period; 144 bit cycles, then 20 low; frame_done pulses once; frame_count=1; frame repeats with no change.
2. mode=01, same data -> successive frames decode as A5,00,FF; 00,FF,A5; FF,A5,00; then back to A5,00,FF.
3. mode=10 -> frames decode as A5,00,FF; FF,A5,00; 00,FF,A5.
4. load_req {11,22,33} at bit 5 of a mode=01 frame -> current frame finishes unchanged; next frame is exactly 11,22,33 (not rotated); rotation resumes after that.
5. mode=11 for one frame -> 24 pulses, all 2 cycles high; mode=00 afterwards -> original data with no rotation lost.
6. rst asserted at bit 10 -> dout=0, busy=0, frame_count=0 next cycle. enable dropped at bit 10 in a separate run -> frame plus gap completes, frame_done pulses, then busy=0.

Source files
------------

// File: rtl/led_strip_animator.sv
// led_strip_animator
//   Streams a NUM_LEDS-word frame buffer to a WS2812-style single-wire LED
//   strip, generating the per-bit high/low timing itself. After each frame it
//   holds the line low for FRAME_GAP_CYC cycles (strip latch), then rotates the
//   buffer forward, backward or holds it according to mode.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   enable       run frames back to back while high
//   mode[1:0]    00 static, 01 rotate forward, 10 rotate reverse, 11 blank
//   load_req     one-cycle pulse: capture frame_data (deferred while busy)
//   frame_data   new pattern, LED0 in the top BPL bits
//   dout         registered strip data line
//   busy         high whenever a frame (LOAD/SEND/GAP) is in progress
//   frame_done   one-cycle pulse on the last gap cycle
//   frame_count  completed frames, wraps at 16 bits
module led_strip_animator #(
  parameter int NUM_LEDS      = 6,
  parameter int BPL           = 24,
  parameter int T0H_CYC       = 19,
  parameter int T1H_CYC       = 38,
  parameter int TBIT_CYC      = 60,
  parameter int FRAME_GAP_CYC = 720000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    load_req,
  input  logic [NUM_LEDS*BPL-1:0] frame_data,
  output logic                    dout,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             frame_count
);

  localparam int W     = NUM_LEDS * BPL;
  localparam int CYC_W = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
  localparam int GAP_W = (FRAME_GAP_CYC > 1) ? $clog2(FRAME_GAP_CYC) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TBIT_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP_CYC - 1);
  localparam logic [CYC_W:0]   T0H_EXT  = (CYC_W+1)'(T0H_CYC);
  localparam logic [CYC_W:0]   T1H_EXT  = (CYC_W+1)'(T1H_CYC);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t             state_reg, state_next;
  logic [W-1:0]       frame_buf_reg, frame_buf_next;
  logic               pend_reg, pend_next;
  logic [W-1:0]       pend_data_reg, pend_data_next;
  logic [W-1:0]       shift_reg, shift_next;
  logic               blank_reg, blank_next;
  logic [CYC_W-1:0]   cyc_reg, cyc_next;
  logic [BIT_W-1:0]   bit_reg, bit_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic               dout_reg, dout_next;
  logic [15:0]        count_reg, count_next;

  logic [W-1:0]       load_src;
  logic [CYC_W:0]     cyc_inc;
  logic               cur_bit_one;

  // The frame to transmit: a deferred load takes priority over the buffer.
  assign load_src    = pend_reg ? pend_data_reg : frame_buf_reg;
  assign cyc_inc     = {1'b0, cyc_reg} + (CYC_W+1)'(1);
  assign cur_bit_one = shift_reg[W-1] & ~blank_reg;

  always_comb begin
    state_next     = state_reg;
    frame_buf_next = frame_buf_reg;
    pend_next      = pend_reg;
    pend_data_next = pend_data_reg;
    shift_next     = shift_reg;
    blank_next     = blank_reg;
    cyc_next       = cyc_reg;
    bit_next       = bit_reg;
    gap_next       = gap_reg;
    count_next     = count_reg;
    dout_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_req) begin
          frame_buf_next = frame_data;
          pend_next      = 1'b0;
        end
        if (enable) state_next = LOAD;
      end

      LOAD: begin
        frame_buf_next = load_src;
        pend_next      = 1'b0;
        shift_next     = load_src;
        blank_next     = (mode == 2'b11);
        cyc_next       = '0;
        bit_next       = '0;
        // dout is registered, so cycle 0 of bit 0 (always high) is set up here.
        dout_next      = 1'b1;
        state_next     = SEND;
      end

      SEND: begin
        if (cyc_reg == CYC_LAST) begin
          cyc_next = '0;
          if (bit_reg == BIT_LAST) begin
            gap_next   = '0;
            state_next = GAP;
          end else begin
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = {shift_reg[W-2:0], 1'b0};
            blank_next = (mode == 2'b11);
            dout_next  = 1'b1;
          end
        end else begin
          cyc_next  = cyc_reg + CYC_W'(1);
          // Look one cycle ahead so the registered line shows the right level.
          dout_next = (cyc_inc < (cur_bit_one ? T1H_EXT : T0H_EXT));
        end
      end

      GAP: begin
        if (gap_reg == GAP_LAST) begin
          count_next = count_reg + 16'd1;
          // A deferred load replaces the buffer at the next LOAD, unrotated.
          if (!pend_reg) begin
            case (mode)
              2'b01:   frame_buf_next = {frame_buf_reg[W-BPL-1:0], frame_buf_reg[W-1 -: BPL]};
              2'b10:   frame_buf_next = {frame_buf_reg[BPL-1:0], frame_buf_reg[W-1:BPL]};
              default: frame_buf_next = frame_buf_reg;
            endcase
          end
          state_next = enable ? LOAD : IDLE;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase

    // Requests while a frame runs are parked; the newest one wins.
    if (load_req && (state_reg != IDLE)) begin
      pend_next      = 1'b1;
      pend_data_next = frame_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      frame_buf_reg <= '0;
      pend_reg      <= 1'b0;
      pend_data_reg <= '0;
      shift_reg     <= '0;
      blank_reg     <= 1'b0;
      cyc_reg       <= '0;
      bit_reg       <= '0;
      gap_reg       <= '0;
      dout_reg      <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      frame_buf_reg <= frame_buf_next;
      pend_reg      <= pend_next;
      pend_data_reg <= pend_data_next;
      shift_reg     <= shift_next;
      blank_reg     <= blank_next;
      cyc_reg       <= cyc_next;
      bit_reg       <= bit_next;
      gap_reg       <= gap_next;
      dout_reg      <= dout_next;
      count_reg     <= count_next;
    end
  end

  assign dout        = dout_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_done  = (state_reg == GAP) && (gap_reg == GAP_LAST);
  assign frame_count = count_reg;

endmodule

// File: tb/tb_led_strip_animator.sv
// tb_led_strip_animator
//   Directed bench for led_strip_animator with a small strip (3 LEDs x 8 bits,
//   6-cycle bits, 20-cycle gap). A frame-position model predicts dout, busy,
//   frame_done and frame_count each cycle; a pulse-width decoder turns the
//   strip waveform back into words that are compared with hand-written values.
module tb_led_strip_animator;

  localparam int N    = 3;
  localparam int BPL  = 8;
  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int TBIT = 6;
  localparam int GAP  = 20;
  localparam int NB   = N * BPL;
  localparam int LAST = NB * TBIT + GAP;   // frame position of the last gap cycle

  logic          clk;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic          load_req;
  logic [NB-1:0] frame_data;
  logic          dout;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_count;

  led_strip_animator #(
    .NUM_LEDS(N), .BPL(BPL), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .TBIT_CYC(TBIT), .FRAME_GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load_req(load_req),
    .frame_data(frame_data), .dout(dout), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking_on = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a sequence of positions: 0 = load, 1..NB*TBIT = bit cycles,
  // then GAP low cycles ending at LAST.
  bit          m_active = 1'b0;
  int          m_pos    = 0;
  logic [7:0]  m_buf [N];
  bit          m_pend   = 1'b0;
  logic [NB-1:0] m_pend_data = '0;
  logic [NB-1:0] m_snap = '0;
  bit          m_blank [NB];
  logic [15:0] m_count = '0;

  function automatic logic [NB-1:0] pack_buf();
    logic [NB-1:0] r;
    for (int i = 0; i < N; i++) r[(N-1-i)*BPL +: BPL] = m_buf[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_pos = 0; m_pend = 1'b0; m_pend_data = '0;
      m_snap = '0; m_count = '0;
      for (int i = 0; i < N; i++) m_buf[i] = '0;
      for (int b = 0; b < NB; b++) m_blank[b] = 1'b0;
    end else if (!m_active) begin
      if (load_req) begin
        for (int i = 0; i < N; i++) m_buf[i] = frame_data[(N-1-i)*BPL +: BPL];
        m_pend = 1'b0;
      end
      if (enable) begin m_active = 1'b1; m_pos = 0; end
    end else begin
      if (m_pos == 0) begin
        if (m_pend) begin
          for (int i = 0; i < N; i++) m_buf[i] = m_pend_data[(N-1-i)*BPL +: BPL];
          m_pend = 1'b0;
        end
        m_snap = pack_buf();
      end
      // Blanking is decided by the mode seen just before each bit starts.
      if ((m_pos % TBIT == 0) && (m_pos / TBIT < NB)) m_blank[m_pos / TBIT] = (mode == 2'b11);
      if (m_pos == LAST) begin
        logic [7:0] old [N];
        m_count = m_count + 16'd1;
        for (int i = 0; i < N; i++) old[i] = m_buf[i];
        if (!m_pend && mode == 2'b01) for (int i = 0; i < N; i++) m_buf[i] = old[(i+1) % N];
        if (!m_pend && mode == 2'b10) for (int i = 0; i < N; i++) m_buf[i] = old[(i+N-1) % N];
        if (enable) m_pos = 0; else m_active = 1'b0;
      end else begin
        m_pos++;
      end
      if (load_req) begin m_pend = 1'b1; m_pend_data = frame_data; end
    end
  end

  function automatic logic exp_dout();
    int k, b, c;
    logic v;
    if (!m_active || m_pos < 1 || m_pos > NB*TBIT) return 1'b0;
    k = m_pos - 1;
    b = k / TBIT;
    c = k % TBIT;
    v = m_snap[NB-1-b] && !m_blank[b];
    return (c < (v ? T1H : T0H));
  endfunction

  always @(negedge clk) begin
    if (checking_on) begin
      cmp("dout",        {31'd0, dout},       {31'd0, exp_dout()});
      cmp("busy",        {31'd0, busy},       {31'd0, m_active});
      cmp("frame_done",  {31'd0, frame_done}, {31'd0, (m_active && m_pos == LAST)});
      cmp("frame_count", {16'd0, frame_count}, {16'd0, m_count});
    end
  end

  // ---------------- waveform decoder ----------------
  int            hi_run = 0;
  int            pulses = 0;
  int            badw   = 0;
  logic [NB-1:0] acc    = '0;
  logic [NB-1:0] last_word = '0;
  int            last_pulses = 0;
  int            last_badw   = 0;

  always @(negedge clk) begin
    if (!busy) begin
      hi_run = 0; pulses = 0; badw = 0; acc = '0;
    end else begin
      if (dout) begin
        hi_run++;
      end else if (hi_run > 0) begin
        acc = {acc[NB-2:0], (hi_run == T1H)};
        pulses++;
        if (hi_run != T0H && hi_run != T1H) badw++;
        hi_run = 0;
      end
      if (frame_done) begin
        last_word = acc; last_pulses = pulses; last_badw = badw;
        acc = '0; pulses = 0; badw = 0;
      end
    end
  end

  // Wait (bounded) for the next frame_done, then check the decoded frame.
  // Returns on the negedge of the cycle after frame_done.
  task automatic wait_frame(input string tag, input logic [NB-1:0] exp_word);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 4 * LAST);
    if (frame_done !== 1'b1) begin
      cmp({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      cmp({tag, "_word"},   {8'd0, last_word}, {8'd0, exp_word});
      cmp({tag, "_pulses"}, last_pulses,       NB);
      cmp({tag, "_widths"}, last_badw,         32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'b00; load_req = 1'b0; frame_data = '0;
    repeat (3) @(negedge clk);
    checking_on = 1'b1;
    cmp("reset_dout",  {31'd0, dout},  32'd0);
    cmp("reset_busy",  {31'd0, busy},  32'd0);
    cmp("reset_done",  {31'd0, frame_done}, 32'd0);
    cmp("reset_count", {16'd0, frame_count}, 32'd0);
    rst = 1'b0;

    // 1: static frame repeats unchanged
    load_req = 1'b1; frame_data = 24'hA500FF;
    @(negedge clk);
    load_req = 1'b0; enable = 1'b1;
    wait_frame("f1", 24'hA500FF);
    cmp("f1_count", {16'd0, frame_count}, 32'd1);
    wait_frame("f2", 24'hA500FF);
    cmp("f2_count", {16'd0, frame_count}, 32'd2);

    // 2: forward rotation
    mode = 2'b01;
    wait_frame("f3", 24'hA500FF);
    wait_frame("f4", 24'h00FFA5);
    wait_frame("f5", 24'hFFA500);

    // 3: reverse rotation (frame 6 also closes the forward cycle)
    mode = 2'b10;
    wait_frame("f6", 24'hA500FF);
    wait_frame("f7", 24'hFFA500);
    wait_frame("f8", 24'h00FFA5);

    // 4: load while busy is deferred and applied unrotated
    mode = 2'b01;
    repeat (5 * TBIT) @(negedge clk);
    load_req = 1'b1; frame_data = 24'h112233;
    @(negedge clk);
    load_req = 1'b0;
    wait_frame("f9",  24'hA500FF);
    wait_frame("f10", 24'h112233);
    wait_frame("f11", 24'h223311);

    // 5: blanking for one frame, then static
    mode = 2'b11;
    wait_frame("f12", 24'h000000);
    mode = 2'b00;
    wait_frame("f13", 24'h331122);
    wait_frame("f14", 24'h331122);
    cmp("f14_count", {16'd0, frame_count}, 32'd14);

    // 6a: reset mid-frame
    repeat (10 * TBIT) @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    cmp("midrst_dout",  {31'd0, dout},  32'd0);
    cmp("midrst_busy",  {31'd0, busy},  32'd0);
    cmp("midrst_count", {16'd0, frame_count}, 32'd0);
    rst = 1'b0;

    // 6b: enable dropped mid-frame; frame and gap still complete
    load_req = 1'b1; frame_data = 24'hA500FF;
    @(negedge clk);
    load_req = 1'b0; enable = 1'b1;
    repeat (1 + 10 * TBIT) @(negedge clk);
    enable = 1'b0;
    wait_frame("f_stop", 24'hA500FF);
    cmp("stop_busy",  {31'd0, busy}, 32'd0);
    cmp("stop_count", {16'd0, frame_count}, 32'd1);
    repeat (5) @(negedge clk);
    cmp("stop_idle_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
